// File: rtl/width_up_fifo_if.sv
// -----------------------------------------------------------------------------
// width_up_fifo_if
//
// Bundles the write side, read side, flush and occupancy of width_up_fifo.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge exactly
// when valid=1 and ready=1 in that cycle. The producer holds data stable while
// valid=1 and ready=0. in_ready never depends on out_ready in the same cycle,
// and out_valid depends only on registered occupancy, so no combinational path
// runs from one side's ready to the other side's valid/ready.
//
// Signals
//   flush     : synchronous clear of stored data (driven by the master)
//   in_valid  : in_data holds a word to write
//   in_ready  : fifo can accept a word this cycle
//   in_data   : IN_W-bit input word
//   out_valid : out_data holds a complete packed word
//   out_ready : consumer takes out_data this cycle
//   out_data  : IN_W*RATIO-bit packed word, oldest word in the top field
//   count     : stored input words, registered
//
// Modports
//   slave  : the fifo itself
//   master : the environment that writes and reads the fifo
// -----------------------------------------------------------------------------
interface width_up_fifo_if #(
  parameter int IN_W  = 4,
  parameter int RATIO = 2,
  parameter int DEPTH = 16
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  count
  );
endinterface

// File: rtl/width_up_fifo.sv
// -----------------------------------------------------------------------------
// width_up_fifo
//
// Width-up FIFO: accepts IN_W-bit words one at a time and presents them
// RATIO at a time as one packed IN_W*RATIO-bit word, first-word-fall-through.
// The oldest word of a group sits in the most significant field, the newest
// in bits [IN_W-1:0].
//
// Parameters
//   IN_W  : input word width in bits
//   RATIO : input words per output word (2, 4 or 8)
//   DEPTH : capacity in input words (power of 2, multiple of RATIO,
//           at least 2*RATIO)
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous, active-low reset; clears pointers and count
//   bus  : width_up_fifo_if.slave (flush, in_*, out_*, count)
//
// Storage is a circular buffer of DEPTH input words addressed by wr_ptr and
// rd_ptr. Because DEPTH is a power of two and a multiple of RATIO, natural
// pointer overflow gives the modulo-DEPTH wrap for free, and a read group
// whose words straddle the DEPTH-1 / 0 boundary is assembled in arrival order
// simply by adding the field offset to rd_ptr.
// -----------------------------------------------------------------------------
module width_up_fifo #(
  parameter int IN_W  = 4,
  parameter int RATIO = 2,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  width_up_fifo_if.slave  bus
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Sized copies of the parameters so comparisons and arithmetic on count
  // stay at one width.
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
  localparam logic [PTR_W-1:0] STEP_C  = PTR_W'(RATIO);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic             in_ready_c;
  logic             out_valid_c;
  logic             wr_en;
  logic             rd_en;
  logic [OUT_W-1:0] packed_word;
  logic [CNT_W-1:0] count_next;

  // in_ready is low while reset is held so nothing is accepted during the
  // reset cycle; it never looks at out_ready, so a full fifo refuses a word
  // even if a read frees space on the same edge.
  assign in_ready_c  = rst && !bus.flush && (count_q < DEPTH_C);

  // out_valid comes from registered count only. It is masked while rst is
  // low so a held reset never shows the stale group about to be dropped.
  assign out_valid_c = rst && (count_q >= RATIO_C);

  assign wr_en = bus.in_valid && in_ready_c;
  assign rd_en = out_valid_c && bus.out_ready;

  // Write and read may both happen on one edge; both adjust count.
  // A read removes RATIO words, which is safe because rd_en implies
  // count >= RATIO, and a write only happens below DEPTH, so the result
  // stays within 0..DEPTH.
  always_comb begin
    count_next = count_q;
    if (wr_en) begin
      count_next = count_next + CNT_W'(1);
    end
    if (rd_en) begin
      count_next = count_next - RATIO_C;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // Reset outranks flush, and flush outranks any write or read presented in
  // the same cycle (those transfers are simply discarded).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + STEP_C;
      end
      count_q <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // Contents are never cleared; pointers and count alone define what is
  // valid. wr_en already excludes reset and flush cycles.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  // Field k (k=0 is the oldest word) is read from rd_ptr+k and placed k fields
  // below the top. The PTR_W-bit add wraps, which handles groups that straddle
  // the end of the buffer.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      packed_word[IN_W*(RATIO-k)-1 -: IN_W] = mem[rd_ptr + PTR_W'(k)];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? packed_word : '0;
  assign bus.count     = count_q;

endmodule
